// File: rtl/qr_cordic.sv
// QR triangularisation of an 8x4 S4.8 matrix by folded CORDIC Givens rotations.
// Rows are loaded, rotated in place into R, then streamed out in input row order.
module qr_cordic #(
    parameter int unsigned DATA_LENGTH = 13,
    parameter int unsigned NUM_SIGN    = 2,
    parameter int unsigned ITER_IDX    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid,
    input  logic [4*DATA_LENGTH-1:0] in,
    output logic                     out_vallid,
    output logic [4*DATA_LENGTH-1:0] out
);
    localparam int unsigned IW    = DATA_LENGTH + 2;
    localparam int unsigned NSTEP = (2 ** ITER_IDX) / NUM_SIGN;
    localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef logic signed [IW-1:0] ival_t;
    typedef enum logic [2:0] {StIdle, StLoad, StRot, StScale, StOut} state_e;

    state_e                 state_q;
    logic [2:0]             row_q;
    logic [1:0]             col_q;
    logic [2:0]             pair_q;
    logic [SW-1:0]          step_q;
    ival_t                  wx_q [4];
    ival_t                  wy_q [4];
    logic [DATA_LENGTH-1:0] ram_q [8][4];

    logic [2:0]          pair_m1;
    logic                neg;
    logic                up;
    logic [ITER_IDX-1:0] sh;
    ival_t               rx [4];
    ival_t               ry [4];
    ival_t               sx [4];
    ival_t               sy [4];
    ival_t               tx;
    ival_t               ty;

    assign pair_m1 = pair_q - 3'd1;

    function automatic ival_t sext(logic [DATA_LENGTH-1:0] v);
        return {{(IW - DATA_LENGTH){v[DATA_LENGTH-1]}}, v};
    endfunction

    // Multiply by ~1/K, then clamp into the storage range.
    function automatic logic [DATA_LENGTH-1:0] scale_sat(ival_t v);
        ival_t                    s;
        logic [IW-DATA_LENGTH:0]  hi;
        s  = (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
        hi = s[IW-1:DATA_LENGTH-1];
        if ((&hi) || !(|hi)) return s[DATA_LENGTH-1:0];
        if (s[IW-1])         return {1'b1, {(DATA_LENGTH - 1){1'b0}}};
        return {1'b0, {(DATA_LENGTH - 1){1'b1}}};
    endfunction

    // First ROT cycle reads the pair straight from the matrix, sign-normalised on the pivot.
    always_comb begin
        neg = ram_q[pair_m1][col_q][DATA_LENGTH-1];
        for (int c = 0; c < 4; c++) begin
            rx[c] = sext(ram_q[pair_m1][c]);
            ry[c] = sext(ram_q[pair_q][c]);
            if (neg) begin
                rx[c] = -rx[c];
                ry[c] = -ry[c];
            end
            sx[c] = (step_q == '0) ? rx[c] : wx_q[c];
            sy[c] = (step_q == '0) ? ry[c] : wy_q[c];
        end
        up = 1'b0;
        sh = '0;
        tx = '0;
        ty = '0;
        for (int s = 0; s < NUM_SIGN; s++) begin
            sh = ITER_IDX'(int'(step_q) * NUM_SIGN + s);
            up = ~sy[col_q][IW-1];
            for (int c = 0; c < 4; c++) begin
                tx    = sx[c];
                ty    = sy[c];
                sx[c] = up ? tx + (ty >>> sh) : tx - (ty >>> sh);
                sy[c] = up ? ty - (tx >>> sh) : ty + (tx >>> sh);
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == StIdle || state_q == StLoad) && valid) begin
            for (int c = 0; c < 4; c++) begin
                ram_q[row_q][c] <= in[DATA_LENGTH*c +: DATA_LENGTH];
            end
        end else if (state_q == StScale) begin
            for (int c = 0; c < 4; c++) begin
                if (2'(c) >= col_q) begin
                    ram_q[pair_m1][c] <= scale_sat(wx_q[c]);
                    ram_q[pair_q][c]  <= (2'(c) == col_q) ? '0 : scale_sat(wy_q[c]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            pair_q     <= 3'd7;
            step_q     <= '0;
            out_vallid <= 1'b0;
            out        <= '0;
            for (int c = 0; c < 4; c++) begin
                wx_q[c] <= '0;
                wy_q[c] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        row_q   <= row_q + 3'd1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (valid) begin
                        row_q <= row_q + 3'd1;
                        if (row_q == 3'd7) begin
                            state_q <= StRot;
                            col_q   <= '0;
                            pair_q  <= 3'd7;
                            step_q  <= '0;
                        end
                    end
                end
                StRot: begin
                    wx_q   <= sx;
                    wy_q   <= sy;
                    step_q <= step_q + 1'b1;
                    if (step_q == SW'(NSTEP - 1)) state_q <= StScale;
                end
                StScale: begin
                    step_q <= '0;
                    if (pair_q == {1'b0, col_q} + 3'd1) begin
                        if (col_q == 2'd3) begin
                            // Row 0 is untouched by the final rotation, so it can go out now.
                            state_q    <= StOut;
                            out_vallid <= 1'b1;
                            row_q      <= 3'd1;
                            for (int c = 0; c < 4; c++) begin
                                out[DATA_LENGTH*c +: DATA_LENGTH] <= ram_q[0][c];
                            end
                        end else begin
                            col_q   <= col_q + 2'd1;
                            pair_q  <= 3'd7;
                            state_q <= StRot;
                        end
                    end else begin
                        pair_q  <= pair_q - 3'd1;
                        state_q <= StRot;
                    end
                end
                StOut: begin
                    if (row_q == '0) begin
                        out_vallid <= 1'b0;
                        out        <= '0;
                        state_q    <= StIdle;
                    end else begin
                        row_q <= row_q + 3'd1;
                        for (int c = 0; c < 4; c++) begin
                            out[DATA_LENGTH*c +: DATA_LENGTH] <= ram_q[row_q][c];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_qr_cordic.sv
// Self-checking bench for qr_cordic: directed and random matrices against a
// plain-arithmetic model of the rotation schedule, gain and saturation rules.
module tb_qr_cordic;
    localparam int DL = 13;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          valid  = 1'b0;
    logic [51:0]   in_row = '0;
    logic          out_vallid;
    logic [51:0]   out_row;

    int passes = 0;
    int checks = 0;
    int a_m [8][4];
    int r_m [8][4];
    logic [51:0] got [8];
    int   lat;
    int   vcnt;
    logic tail_v;
    logic [51:0] tail_o;

    qr_cordic dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .in        (in_row),
        .out_vallid(out_vallid),
        .out       (out_row)
    );

    always #5 clk = ~clk;

    function automatic int sat13(int v);
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    function automatic int gain(int v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction

    // Reference: Givens vectoring on row pairs, 8 micro-steps, then 1/K gain and clamp.
    task automatic model_qr();
        int m [8][4];
        int x [4];
        int y [4];
        int nx, ny;
        bit neg, up;
        m = a_m;
        for (int j = 0; j < 4; j++) begin
            for (int k = 7; k > j; k--) begin
                neg = (m[k-1][j] < 0);
                for (int c = 0; c < 4; c++) begin
                    x[c] = neg ? -m[k-1][c] : m[k-1][c];
                    y[c] = neg ? -m[k][c]   : m[k][c];
                end
                for (int i = 0; i < 8; i++) begin
                    up = (y[j] >= 0);
                    for (int c = j; c < 4; c++) begin
                        nx = up ? x[c] + (y[c] >>> i) : x[c] - (y[c] >>> i);
                        ny = up ? y[c] - (x[c] >>> i) : y[c] + (x[c] >>> i);
                        x[c] = nx;
                        y[c] = ny;
                    end
                end
                for (int c = j; c < 4; c++) begin
                    m[k-1][c] = sat13(gain(x[c]));
                    m[k][c]   = (c == j) ? 0 : sat13(gain(y[c]));
                end
            end
        end
        r_m = m;
    endtask

    function automatic logic [51:0] pack_in(int r);
        logic [51:0] p;
        for (int c = 0; c < 4; c++) p[DL*c +: DL] = DL'(a_m[r][c]);
        return p;
    endfunction

    function automatic logic [51:0] exp_row(int n);
        logic [51:0] p;
        for (int c = 0; c < 4; c++) p[DL*c +: DL] = DL'(r_m[n][c]);
        return p;
    endfunction

    function automatic int fld(logic [51:0] v, int c);
        logic [DL-1:0] t;
        t = v[DL*c +: DL];
        return int'($signed(t));
    endfunction

    task automatic clear_matrix();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) a_m[r][c] = 0;
    endtask

    task automatic rand_matrix();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++) a_m[r][c] = int'($urandom_range(0, 4096)) - 2048;
    endtask

    task automatic load_rows(input bit gaps);
        for (int r = 0; r < 8; r++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                valid  = 1'b0;
                in_row = 52'({$urandom(), $urandom()});
                @(negedge clk);
            end
            valid  = 1'b1;
            in_row = pack_in(r);
            @(negedge clk);
        end
        valid  = 1'b0;
        in_row = '0;
    endtask

    // lat counts edges after the one that stored row 7.
    task automatic collect(input bit junk);
        lat = 0;
        while (!out_vallid && lat < 300) begin
            valid  = junk && (lat < 40);
            in_row = junk ? 52'({$urandom(), $urandom()}) : '0;
            @(negedge clk);
            lat++;
        end
        valid  = 1'b0;
        in_row = '0;
        vcnt   = 0;
        for (int n = 0; n < 8; n++) begin
            got[n] = out_row;
            if (out_vallid) vcnt++;
            @(negedge clk);
        end
        tail_v = out_vallid;
        tail_o = out_row;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_vallid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_vallid);
        else passes++;
        checks++;
        if (out_row !== '0) $display("FAIL reset_out got %h want 0", out_row);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        clear_matrix();
        model_qr();
        load_rows(1'b1);
        collect(1'b0);
        checks++;
        if (lat !== 110) $display("FAIL zero_latency got %0d want 110", lat);
        else passes++;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got[n] !== exp_row(n)) $display("FAIL zero_row%0d got %h want %h", n, got[n], exp_row(n));
            else passes++;
        end
        checks++;
        if (vcnt !== 8 || tail_v !== 1'b0 || tail_o !== '0)
            $display("FAIL zero_window got cnt=%0d tail=%b/%h want 8/0/0", vcnt, tail_v, tail_o);
        else passes++;
    endtask

    task automatic test_unit(input int s);
        clear_matrix();
        a_m[0][0] = s;
        model_qr();
        load_rows(1'b0);
        collect(1'b0);
        checks++;
        if (lat !== 110) $display("FAIL unit%0d_latency got %0d want 110", s, lat);
        else passes++;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got[n] !== exp_row(n))
                $display("FAIL unit%0d_row%0d got %h want %h", s, n, got[n], exp_row(n));
            else passes++;
        end
        checks++;
        if (fld(got[0], 0) < 254 || fld(got[0], 0) > 258)
            $display("FAIL unit%0d_r00 got %0d want 256+-2", s, fld(got[0], 0));
        else passes++;
    endtask

    task automatic test_identity();
        clear_matrix();
        for (int r = 0; r < 4; r++) a_m[r][r] = 256;
        model_qr();
        load_rows(1'b1);
        collect(1'b0);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got[n] !== exp_row(n)) $display("FAIL ident_row%0d got %h want %h", n, got[n], exp_row(n));
            else passes++;
        end
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (fld(got[r], r) < 240 || fld(got[r], r) > 272)
                $display("FAIL ident_diag%0d got %0d want near 256", r, fld(got[r], r));
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        for (int job = 0; job < 4; job++) begin
            rand_matrix();
            model_qr();
            load_rows(job[0]);
            collect(job == 1);
            checks++;
            if (lat !== 110) $display("FAIL b2b%0d_latency got %0d want 110", job, lat);
            else passes++;
            for (int n = 0; n < 8; n++) begin
                checks++;
                if (got[n] !== exp_row(n))
                    $display("FAIL b2b%0d_row%0d got %h want %h", job, n, got[n], exp_row(n));
                else passes++;
            end
            checks++;
            if (vcnt !== 8 || tail_v !== 1'b0)
                $display("FAIL b2b%0d_window got cnt=%0d tail=%b want 8/0", job, vcnt, tail_v);
            else passes++;
        end
    endtask

    task automatic test_abort();
        int cnt;
        rand_matrix();
        load_rows(1'b0);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (out_vallid !== 1'b0 || out_row !== '0)
            $display("FAIL abort_reset got %b/%h want 0/0", out_vallid, out_row);
        else passes++;
        cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (out_vallid) cnt++;
        end
        checks++;
        if (cnt !== 0) $display("FAIL abort_quiet got %0d valid cycles want 0", cnt);
        else passes++;
        rand_matrix();
        model_qr();
        load_rows(1'b1);
        collect(1'b0);
        checks++;
        if (lat !== 110) $display("FAIL abort_latency got %0d want 110", lat);
        else passes++;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (got[n] !== exp_row(n)) $display("FAIL abort_row%0d got %h want %h", n, got[n], exp_row(n));
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_unit(256);
        test_unit(-256);
        test_identity();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
